// File: rtl/xor_8bit.sv
// rtl/xor_8bit.sv - combinational XOR with registered capture, parity, zero, Hamming distance and running checksum
module xor_8bit #(
  parameter int WIDTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [WIDTH-1:0]             a,
  input  logic [WIDTH-1:0]             b,
  input  logic                         en,
  input  logic                         clr,
  output logic [WIDTH-1:0]             out,
  output logic [WIDTH-1:0]             out_q,
  output logic                         parity_q,
  output logic                         zero_q,
  output logic [$clog2(WIDTH+1)-1:0]   hd_q,
  output logic [WIDTH-1:0]             csum_q,
  output logic                         valid_q
);

  localparam int HW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] x;
  logic [HW-1:0]    pop;
  logic [WIDTH-1:0] csum_base;

  logic [WIDTH-1:0] out_d;
  logic             parity_d;
  logic             zero_d;
  logic [HW-1:0]    hd_d;
  logic [WIDTH-1:0] csum_d;
  logic             valid_d;

  always_comb begin
    x   = a ^ b;
    out = x;
    pop = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop = pop + HW'(x[i]);
    end
  end

  always_comb begin
    out_d    = out_q;
    parity_d = parity_q;
    zero_d   = zero_q;
    hd_d     = hd_q;
    valid_d  = 1'b0;
    if (en) begin
      out_d    = x;
      parity_d = ^x;
      zero_d   = (x == '0);
      hd_d     = pop;
      valid_d  = 1'b1;
    end
    // Clear takes effect before the fold, so clr+en restarts the checksum at a^b.
    csum_base = clr ? '0 : csum_q;
    csum_d    = en ? (csum_base ^ x) : csum_base;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q    <= '0;
      parity_q <= 1'b0;
      zero_q   <= 1'b0;
      hd_q     <= '0;
      csum_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      out_q    <= out_d;
      parity_q <= parity_d;
      zero_q   <= zero_d;
      hd_q     <= hd_d;
      csum_q   <= csum_d;
      valid_q  <= valid_d;
    end
  end

endmodule

// File: tb/tb_xor_8bit.sv
// tb/tb_xor_8bit.sv - directed and random self-checking bench for xor_8bit
module tb_xor_8bit;

  logic       clk;
  logic       rst;
  logic [7:0] a;
  logic [7:0] b;
  logic       en;
  logic       clr;
  logic [7:0] out;
  logic [7:0] out_q;
  logic       parity_q;
  logic       zero_q;
  logic [3:0] hd_q;
  logic [7:0] csum_q;
  logic       valid_q;

  int n_checks = 0;
  int n_pass   = 0;

  xor_8bit #(.WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .a        (a),
    .b        (b),
    .en       (en),
    .clr      (clr),
    .out      (out),
    .out_q    (out_q),
    .parity_q (parity_q),
    .zero_q   (zero_q),
    .hd_q     (hd_q),
    .csum_q   (csum_q),
    .valid_q  (valid_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hand-computed table: operands, a^b, popcount, parity, zero, running checksum
  logic [7:0] va   [8] = '{8'hFF, 8'h00, 8'hFF, 8'h55, 8'h00, 8'h84, 8'h88, 8'h90};
  logic [7:0] vb   [8] = '{8'h4A, 8'hFF, 8'h81, 8'hAA, 8'h00, 8'h40, 8'h85, 8'h97};
  logic [7:0] vx   [8] = '{8'hB5, 8'hFF, 8'h7E, 8'hFF, 8'h00, 8'hC4, 8'h0D, 8'h07};
  logic [3:0] vhd  [8] = '{4'd5, 4'd8, 4'd6, 4'd8, 4'd0, 4'd3, 4'd3, 4'd3};
  logic       vpar [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
  logic       vzer [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic [7:0] vcs  [8] = '{8'hB5, 8'h4A, 8'h34, 8'hCB, 8'hCB, 8'h0F, 8'h02, 8'h05};

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; a = 8'h00; b = 8'h00;

    for (int i = 0; i < 8; i++) begin
      a = va[i]; b = vb[i];
      #50;
      chk("comb_out", out, vx[i]);
    end

    tick();
    chk("rst_out_q", out_q, 8'h00);
    chk("rst_parity", parity_q, 1'b0);
    chk("rst_zero", zero_q, 1'b0);
    chk("rst_hd", hd_q, 4'd0);
    chk("rst_csum", csum_q, 8'h00);
    chk("rst_valid", valid_q, 1'b0);

    rst = 1'b0;
    a = 8'hFF; b = 8'h4A; en = 1'b1;
    tick();
    en = 1'b0; a = 8'h12; b = 8'h13;
    chk("cap_out_q", out_q, 8'hB5);
    chk("cap_parity", parity_q, 1'b1);
    chk("cap_zero", zero_q, 1'b0);
    chk("cap_hd", hd_q, 4'd5);
    chk("cap_valid", valid_q, 1'b1);
    tick();
    chk("hold_valid", valid_q, 1'b0);
    chk("hold_out_q", out_q, 8'hB5);
    chk("hold_hd", hd_q, 4'd5);
    chk("hold_csum", csum_q, 8'hB5);

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      a = va[i]; b = vb[i]; en = 1'b1;
      tick();
      chk("seq_csum", csum_q, vcs[i]);
      chk("seq_out_q", out_q, vx[i]);
      chk("seq_hd", hd_q, vhd[i]);
      chk("seq_parity", parity_q, vpar[i]);
      chk("seq_zero", zero_q, vzer[i]);
      chk("seq_valid", valid_q, 1'b1);
    end
    en = 1'b0;

    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a = va[i]; b = vb[i]; en = 1'b1;
      tick();
    end
    chk("pre_clr_csum", csum_q, 8'h0F);
    a = 8'h88; b = 8'h85; en = 1'b1; clr = 1'b1;
    tick();
    chk("clr_en_csum", csum_q, 8'h0D);
    chk("clr_en_out_q", out_q, 8'h0D);
    en = 1'b0; clr = 1'b1; a = 8'hF0; b = 8'h0F;
    tick();
    chk("clr_only_csum", csum_q, 8'h00);
    chk("clr_only_out_q", out_q, 8'h0D);
    chk("clr_only_valid", valid_q, 1'b0);
    clr = 1'b0;
    tick();
    chk("idle_csum", csum_q, 8'h00);

    a = 8'h3C; b = 8'h0F; en = 1'b1;
    tick();
    chk("pre_rst_csum", csum_q, 8'h33);
    a = 8'h12; b = 8'h34; en = 1'b1; rst = 1'b1;
    tick();
    chk("rst_en_out", out, 8'h26);
    chk("rst_en_out_q", out_q, 8'h00);
    chk("rst_en_parity", parity_q, 1'b0);
    chk("rst_en_zero", zero_q, 1'b0);
    chk("rst_en_hd", hd_q, 4'd0);
    chk("rst_en_csum", csum_q, 8'h00);
    chk("rst_en_valid", valid_q, 1'b0);
    rst = 1'b0;
    a = 8'h0F; b = 8'hF0;
    tick();
    chk("post_rst_csum", csum_q, 8'hFF);
    chk("post_rst_hd", hd_q, 4'd8);

    for (int n = 0; n < 1000; n++) begin
      logic [7:0] ra, rb, rx;
      logic [3:0] rc;
      ra = 8'($urandom); rb = 8'($urandom);
      rx = ra ^ rb;
      rc = 4'd0;
      for (int k = 0; k < 8; k++) if (rx[k]) rc = rc + 4'd1;
      a = ra; b = rb; en = 1'b1;
      tick();
      chk("rnd_out", out, rx);
      chk("rnd_hd", hd_q, rc);
    end
    en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/xor_8bit.md
XOR_8BIT -- requirements
Module: xor_8bit

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width; all requirements below use WIDTH=8.
REQ-002 Port: clk  input  1  rising-edge clock for all registered logic.
REQ-003 Port: rst  input  1  reset, synchronous and active-high.
REQ-004 Port: a  input  8  operand A.
REQ-005 Port: b  input  8  operand B.
REQ-006 Port: en  input  1  capture strobe; when high, registered outputs update from current a^b.
REQ-007 Port: clr  input  1  synchronous clear of running checksum only.
REQ-008 Port: out  output  8  combinational a XOR b.
REQ-009 Port: out_q  output  8  registered a^b captured on en.
REQ-010 Port: parity_q  output  1  registered XOR-reduction of captured result; 1 = odd number of ones.
REQ-011 Port: zero_q  output  1  registered flag; 1 when captured result is 8'h00, i.e. a==b.
REQ-012 Port: hd_q  output  4  registered population count of captured result, i.e. Hamming distance a vs b, range 0..8.
REQ-013 Port: csum_q  output  8  running XOR of all captured results since last reset/clear.
REQ-014 Port: valid_q  output  1  high for exactly the cycle after each capture.
REQ-015 Instances SHALL connect ports by name; no positional port order is guaranteed.

Function
REQ-016 out SHALL equal a ^ b bitwise at all times, with zero clock latency and independent of clk, rst, en, clr.
REQ-017 out bit i SHALL depend only on a[i] and b[i]; no carries or cross-bit effects.
REQ-018 On a rising clk edge with rst=0 and en=1: out_q <= a^b; parity_q <= ^(a^b); zero_q <= (a==b); hd_q <= popcount(a^b); valid_q <= 1.
REQ-019 On a rising clk edge with rst=0 and en=0: out_q, parity_q, zero_q and hd_q SHALL hold their values; valid_q <= 0.
REQ-020 Registered outputs SHALL have a latency of one cycle from the en edge.
REQ-021 csum_q update with rst=0: clr=0,en=1 -> csum_q ^ (a^b); clr=1,en=0 -> 0; clr=1,en=1 -> a^b (the clear applies first, then the fold); clr=0,en=0 -> hold.
REQ-022 hd_q SHALL be 4 bits wide so that the value 8 (a = ~b) is represented without overflow.
REQ-023 csum_q SHALL be modulo-2 per bit with no saturation or wrap flag.
REQ-024 The block SHALL contain no state other than the registered outputs listed.

Reset
REQ-025 On a rising clk edge with rst=1: out_q=8'h00, parity_q=0, zero_q=0, hd_q=0, csum_q=8'h00, valid_q=0.
REQ-026 rst SHALL take priority over en and clr in the same cycle.
REQ-027 Reset asserted between captures SHALL discard any pending checksum; the next capture after reset starts csum_q from 0.
REQ-028 rst SHALL NOT affect out, which remains a^b during reset.
REQ-029 Registered outputs are undefined before the first reset edge; benches SHALL reset before checking them.

Verification
REQ-030 Combinational sweep, en=0, 50 time units per vector, checking out after each step: FF^4A->B5, 00^FF->FF, FF^81->7E, 55^AA->FF, 00^00->00, 84^40->C4, 88^85->0D, 90^97->07.
REQ-031 Capture a=FF, b=4A with en=1 for one cycle -> next cycle out_q=B5, parity_q=1, zero_q=0, hd_q=5, valid_q=1; following cycle with en=0 -> valid_q=0 and out_q still B5.
REQ-032 Capture the eight REQ-030 vectors back-to-back after reset -> csum_q sequence 4A is wrong start; required sequence is B5, 4A, 34, CB, CB, 0F, 02, 05; hd_q for 55^AA is 8; zero_q=1 only for 00^00.
REQ-033 clr=1 and en=1 together with a=88, b=85 while csum_q=0F -> csum_q=0D next cycle.
REQ-034 rst=1 together with en=1 and clr=0 -> all registered outputs 0 next cycle while out still shows a^b.
REQ-035 Randomized check over at least 1000 vectors: out == a^b, and hd_q equals the reference popcount of a^b.
